// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the RV32-subset multi-cycle sequencer: opcodes, ALU codes,
// FSM state encoding and the registered control bundle.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Wide enough for the largest supported MEM_TIMEOUT (255).
  localparam int TMO_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLL = 3'b100
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef struct packed {
    alu_op_e alu_control;
    logic    wd_src;
    logic    imm_reg;
    logic    alu_src;
    logic    mem_to_reg;
    logic    is_load;
    logic    is_store;
    logic    is_lui;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Sequencer <-> datapath/memory bundle. The sequencer is the master: it consumes
// the instruction fields and ready strobes and drives every control line.
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             imem_ready;
  logic             dmem_ready;

  logic             imem_req;
  logic             dmem_req;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             mem_write;
  logic [2:0]       alu_control;
  logic             wd_src;
  logic             imm_reg;
  logic             alu_src;
  logic             mem_to_reg;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] retire_count;

  modport master (
    input  run, opcode, funct3, funct7, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write,
           alu_control, wd_src, imm_reg, alu_src, mem_to_reg,
           busy, fault, retire_count
  );

  modport slave (
    output run, opcode, funct3, funct7, imem_ready, dmem_ready,
    input  imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write,
           alu_control, wd_src, imm_reg, alu_src, mem_to_reg,
           busy, fault, retire_count
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_decoder.sv
// Combinational instruction decoder: opcode/funct3/funct7 -> control bundle plus
// an illegal flag. Illegal encodings return an all-zero bundle.
module multicycle_ctrl_fsm_decoder
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    ctrl    = '0;
    illegal = 1'b0;

    case (opcode)
      OP_R: begin
        ctrl.alu_src = 1'b1;
        ctrl.wd_src  = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD_SUB: ctrl.alu_control = ALU_ADD;
            F3_AND:     ctrl.alu_control = ALU_AND;
            F3_XOR:     ctrl.alu_control = ALU_XOR;
            F3_SLL:     ctrl.alu_control = ALU_SLL;
            default:    illegal = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          ctrl.alu_control = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end

      OP_IMM: begin
        // funct7 carries immediate bits here, so only funct3 qualifies ADDI.
        ctrl.wd_src = 1'b1;
        illegal     = (funct3 != F3_ADD_SUB);
      end

      OP_LOAD: begin
        ctrl.wd_src     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.is_load    = 1'b1;
        illegal         = (funct3 != F3_WORD);
      end

      OP_STORE: begin
        ctrl.wd_src   = 1'b1;
        ctrl.imm_reg  = 1'b1;
        ctrl.is_store = 1'b1;
        illegal       = (funct3 != F3_WORD);
      end

      OP_LUI: begin
        ctrl.is_lui = 1'b1;
      end

      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      ctrl = '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with wait-state memories, traps on illegal decode or timeout.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state;
  ctrl_t            dec_ctrl;
  ctrl_t            ctrl_q;
  logic             dec_illegal;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             imem_req_q;
  logic             dmem_req_q;
  logic             mem_write_q;
  logic             reg_write_q;
  logic             busy_q;
  logic             fault_q;
  logic [CNT_W-1:0] retire_q;
  logic             ir_write;
  logic             pc_write;

  multicycle_ctrl_fsm_decoder u_decoder (
    .opcode  (bus.opcode),
    .funct3  (bus.funct3),
    .funct7  (bus.funct7),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // Current wait cycle is the last one allowed; a ready in this cycle still wins.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // IR/PC strobes must coincide with the cycle the memory reports ready, so they
  // are qualified by the ready input rather than registered a cycle late.
  assign ir_write = (state == ST_FETCH) && bus.imem_ready;
  assign pc_write = reg_write_q
                 || ((state == ST_MEM) && ctrl_q.is_store && bus.dmem_ready);

  always_ff @(posedge clk) begin
    // NOTE: state and registered outputs use <= so every branch sees pre-edge values.
    if (rst) begin
      state       <= ST_IDLE;
      ctrl_q      <= '0;
      tmo_cnt     <= '0;
      imem_req_q  <= 1'b0;
      dmem_req_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.run) begin
            state      <= ST_FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
            tmo_cnt    <= '0;
          end
        end

        ST_FETCH: begin
          if (bus.imem_ready) begin
            state      <= ST_DECODE;
            imem_req_q <= 1'b0;
          end else if (tmo_hit) begin
            state      <= ST_TRAP;
            imem_req_q <= 1'b0;
            fault_q    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_DECODE: begin
          ctrl_q <= dec_ctrl;
          if (dec_illegal) begin
            state   <= ST_TRAP;
            fault_q <= 1'b1;
          end else if (dec_ctrl.is_lui) begin
            state       <= ST_WB;
            reg_write_q <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (ctrl_q.is_load || ctrl_q.is_store) begin
            state       <= ST_MEM;
            dmem_req_q  <= 1'b1;
            mem_write_q <= ctrl_q.is_store;
            tmo_cnt     <= '0;
          end else begin
            state       <= ST_WB;
            reg_write_q <= 1'b1;
          end
        end

        ST_MEM: begin
          if (bus.dmem_ready) begin
            dmem_req_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (ctrl_q.is_load) begin
              state       <= ST_WB;
              reg_write_q <= 1'b1;
            end else if (bus.run) begin
              // Store retires here; continue straight into the next fetch.
              state      <= ST_FETCH;
              imem_req_q <= 1'b1;
              tmo_cnt    <= '0;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end else if (tmo_hit) begin
            state       <= ST_TRAP;
            dmem_req_q  <= 1'b0;
            mem_write_q <= 1'b0;
            fault_q     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        ST_WB: begin
          reg_write_q <= 1'b0;
          if (bus.run) begin
            state      <= ST_FETCH;
            imem_req_q <= 1'b1;
            tmo_cnt    <= '0;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end

        ST_TRAP: begin
          // Parked until reset; all enables were already dropped on entry.
        end

        default: begin
          state       <= ST_TRAP;
          imem_req_q  <= 1'b0;
          dmem_req_q  <= 1'b0;
          mem_write_q <= 1'b0;
          reg_write_q <= 1'b0;
          busy_q      <= 1'b1;
          fault_q     <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (pc_write) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.dmem_req     = dmem_req_q;
  assign bus.ir_write     = ir_write;
  assign bus.pc_write     = pc_write;
  assign bus.reg_write    = reg_write_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.alu_control  = ctrl_q.alu_control;
  assign bus.wd_src       = ctrl_q.wd_src;
  assign bus.imm_reg      = ctrl_q.imm_reg;
  assign bus.alu_src      = ctrl_q.alu_src;
  assign bus.mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.retire_count = retire_q;

endmodule
